// File: rtl/sb_arbiter_pkg.sv
// Shared definitions for the two-master data-memory arbiter: widths, mask
// encodings, FSM states, request/transaction payloads and the legality check.
package sb_arbiter_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned MASK_LEN = 4;
  localparam int unsigned BYTE_SEL = 2;

  localparam logic [XLEN-1:0]     ZERO32 = '0;
  localparam logic [MASK_LEN-1:0] MASK_B = 4'b0001;
  localparam logic [MASK_LEN-1:0] MASK_H = 4'b0011;
  localparam logic [MASK_LEN-1:0] MASK_W = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Request fields presented by a master.
  typedef struct packed {
    logic                we;
    logic [MASK_LEN-1:0] mask;
    logic                un_sign;
    logic [XLEN-1:0]     addr;
    logic [XLEN-1:0]     wdata;
  } mreq_t;

  // What must survive into RESP for the owning master's completion.
  typedef struct packed {
    logic                id;
    logic                we;
    logic [MASK_LEN-1:0] mask;
    logic                un_sign;
    logic                err;
    logic [BYTE_SEL-1:0] off;
  } txn_t;

  function automatic logic access_err(input logic [MASK_LEN-1:0] mask,
                                      input logic [BYTE_SEL-1:0] off);
    logic illegal;
    illegal = (mask != MASK_B) && (mask != MASK_H) && (mask != MASK_W);
    return illegal | ((mask == MASK_H) & off[0]) | ((mask == MASK_W) & (|off));
  endfunction

endpackage

// File: rtl/sb_load_ext.sv
// Combinational load aligner: shifts the addressed lane down and applies
// zero or sign extension for byte and half loads.
module sb_load_ext
  import sb_arbiter_pkg::*;
(
  input  logic [XLEN-1:0]     rdata,
  input  logic [BYTE_SEL-1:0] offset,
  input  logic [MASK_LEN-1:0] mask,
  input  logic                un_sign,
  output logic [XLEN-1:0]     ext_c
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    ext_c   = shifted;
    case (mask)
      MASK_B:  ext_c = {{24{~un_sign & shifted[7]}}, shifted[7:0]};
      MASK_H:  ext_c = {{16{~un_sign & shifted[15]}}, shifted[15:0]};
      default: ext_c = shifted;
    endcase
  end

endmodule

// File: rtl/sb_arbiter.sv
// Two-master arbiter and access sequencer for the data-memory port:
// IDLE grants and captures, ACCESS drives the slave, RESP returns the result.
module sb_arbiter
  import sb_arbiter_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [MASK_LEN-1:0] m0_byte_mask,
  input  logic                m0_un_sign,
  input  logic [XLEN-1:0]     m0_addr,
  input  logic [XLEN-1:0]     m0_wdata,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [MASK_LEN-1:0] m1_byte_mask,
  input  logic                m1_un_sign,
  input  logic [XLEN-1:0]     m1_addr,
  input  logic [XLEN-1:0]     m1_wdata,
  output logic                m0_gnt,
  output logic                m1_gnt,
  output logic                m0_rvalid,
  output logic                m1_rvalid,
  output logic                m0_err,
  output logic                m1_err,
  output logic [XLEN-1:0]     m0_rdata,
  output logic [XLEN-1:0]     m1_rdata,
  output logic                s_en_o,
  output logic [MASK_LEN-1:0] s_rw_o,
  output logic [XLEN-1:0]     s_addr_o,
  output logic [XLEN-1:0]     s_wdata_o,
  input  logic [XLEN-1:0]     s_rdata
);

  state_e              state_q, state_d;
  txn_t                txn_q, txn_d;
  logic                last_q, last_d;
  logic                s_en_q, s_en_d;
  logic [MASK_LEN-1:0] s_rw_q, s_rw_d;
  logic [XLEN-1:0]     s_addr_q, s_addr_d;
  logic [XLEN-1:0]     s_wdata_q, s_wdata_d;

  mreq_t           m0_in, m1_in, sel;
  logic            win;
  logic            sel_err;
  logic [XLEN-1:0] ld_data;

  assign m0_in = '{we: m0_we, mask: m0_byte_mask, un_sign: m0_un_sign,
                   addr: m0_addr, wdata: m0_wdata};
  assign m1_in = '{we: m1_we, mask: m1_byte_mask, un_sign: m1_un_sign,
                   addr: m1_addr, wdata: m1_wdata};

  // Tie goes to the master not granted last (round-robin) or to m0 (fixed).
  always_comb begin
    win = 1'b0;
    if (m0_req && m1_req) win = RR_EN ? ~last_q : 1'b0;
    else if (m1_req)      win = 1'b1;
    sel     = win ? m1_in : m0_in;
    sel_err = access_err(sel.mask, sel.addr[BYTE_SEL-1:0]);
  end

  sb_load_ext u_load_ext (
    .rdata   (s_rdata),
    .offset  (txn_q.off),
    .mask    (txn_q.mask),
    .un_sign (txn_q.un_sign),
    .ext_c   (ld_data)
  );

  always_comb begin
    state_d   = state_q;
    txn_d     = txn_q;
    last_d    = last_q;
    s_en_d    = 1'b0;
    s_rw_d    = '0;
    s_addr_d  = ZERO32;
    s_wdata_d = ZERO32;
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    m0_rvalid = 1'b0;
    m1_rvalid = 1'b0;
    m0_err    = 1'b0;
    m1_err    = 1'b0;
    m0_rdata  = ZERO32;
    m1_rdata  = ZERO32;
    case (state_q)
      ST_IDLE: begin
        if (m0_req || m1_req) begin
          m0_gnt  = ~win;
          m1_gnt  = win;
          last_d  = win;
          state_d = ST_ACCESS;
          txn_d   = '{id: win, we: sel.we, mask: sel.mask, un_sign: sel.un_sign,
                      err: sel_err, off: sel.addr[BYTE_SEL-1:0]};
          // Slave outputs are registered here so they appear during ACCESS.
          if (!sel_err) begin
            s_en_d    = 1'b1;
            s_rw_d    = sel.we ? MASK_LEN'(sel.mask << sel.addr[BYTE_SEL-1:0]) : '0;
            s_addr_d  = {sel.addr[XLEN-1:BYTE_SEL], BYTE_SEL'(0)};
            s_wdata_d = sel.wdata << {sel.addr[BYTE_SEL-1:0], 3'b000};
          end
        end
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP: begin
        state_d = ST_IDLE;
        if (txn_q.id) begin
          m1_rvalid = 1'b1;
          m1_err    = txn_q.err;
          m1_rdata  = (txn_q.we || txn_q.err) ? ZERO32 : ld_data;
        end else begin
          m0_rvalid = 1'b1;
          m0_err    = txn_q.err;
          m0_rdata  = (txn_q.we || txn_q.err) ? ZERO32 : ld_data;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      txn_q     <= '0;
      last_q    <= 1'b1;
      s_en_q    <= 1'b0;
      s_rw_q    <= '0;
      s_addr_q  <= ZERO32;
      s_wdata_q <= ZERO32;
    end else begin
      state_q   <= state_d;
      txn_q     <= txn_d;
      last_q    <= last_d;
      s_en_q    <= s_en_d;
      s_rw_q    <= s_rw_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
    end
  end

  assign s_en_o    = s_en_q;
  assign s_rw_o    = s_rw_q;
  assign s_addr_o  = s_addr_q;
  assign s_wdata_o = s_wdata_q;

endmodule

// File: tb/tb_sb_arbiter.sv
// Directed bench for sb_arbiter: a round-robin and a fixed-priority instance
// share all inputs; expected values are hand-computed constants.
module tb_sb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m0_un_sign, m1_req, m1_we, m1_un_sign;
  logic [3:0]  m0_byte_mask, m1_byte_mask;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, s_rdata;

  logic        r_m0_gnt, r_m1_gnt, r_m0_rvalid, r_m1_rvalid, r_m0_err, r_m1_err;
  logic [31:0] r_m0_rdata, r_m1_rdata, r_s_addr, r_s_wdata;
  logic        r_s_en;
  logic [3:0]  r_s_rw;

  logic        f_m0_gnt, f_m1_gnt, f_m0_rvalid, f_m1_rvalid, f_m0_err, f_m1_err;
  logic [31:0] f_m0_rdata, f_m1_rdata, f_s_addr, f_s_wdata;
  logic        f_s_en;
  logic [3:0]  f_s_rw;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  sb_arbiter #(.RR_EN(1'b1)) u_rr (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_byte_mask(m0_byte_mask),
    .m0_un_sign(m0_un_sign), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_byte_mask(m1_byte_mask),
    .m1_un_sign(m1_un_sign), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_gnt(r_m0_gnt), .m1_gnt(r_m1_gnt),
    .m0_rvalid(r_m0_rvalid), .m1_rvalid(r_m1_rvalid),
    .m0_err(r_m0_err), .m1_err(r_m1_err),
    .m0_rdata(r_m0_rdata), .m1_rdata(r_m1_rdata),
    .s_en_o(r_s_en), .s_rw_o(r_s_rw), .s_addr_o(r_s_addr),
    .s_wdata_o(r_s_wdata), .s_rdata(s_rdata)
  );

  sb_arbiter #(.RR_EN(1'b0)) u_fp (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_byte_mask(m0_byte_mask),
    .m0_un_sign(m0_un_sign), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_byte_mask(m1_byte_mask),
    .m1_un_sign(m1_un_sign), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_gnt(f_m0_gnt), .m1_gnt(f_m1_gnt),
    .m0_rvalid(f_m0_rvalid), .m1_rvalid(f_m1_rvalid),
    .m0_err(f_m0_err), .m1_err(f_m1_err),
    .m0_rdata(f_m0_rdata), .m1_rdata(f_m1_rdata),
    .s_en_o(f_s_en), .s_rw_o(f_s_rw), .s_addr_o(f_s_addr),
    .s_wdata_o(f_s_wdata), .s_rdata(s_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    m0_req = 1'b0; m0_we = 1'b0; m0_byte_mask = 4'b1111; m0_un_sign = 1'b0;
    m0_addr = '0;  m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_byte_mask = 4'b1111; m1_un_sign = 1'b0;
    m1_addr = '0;  m1_wdata = '0;
    s_rdata = '0;
  endtask

  // One single-master transaction on the round-robin instance, starting at a negedge in IDLE.
  task automatic run_txn(input string name, input bit m, input bit we, input logic [3:0] mask,
                         input bit un, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] srd, input logic [3:0] exp_rw,
                         input logic [31:0] exp_saddr, input logic [31:0] exp_swdata,
                         input logic [31:0] exp_rdata, input bit exp_err);
    if (m) begin
      m1_req = 1'b1; m1_we = we; m1_byte_mask = mask; m1_un_sign = un;
      m1_addr = addr; m1_wdata = wdata;
    end else begin
      m0_req = 1'b1; m0_we = we; m0_byte_mask = mask; m0_un_sign = un;
      m0_addr = addr; m0_wdata = wdata;
    end
    #1;
    check({name, " gnt"}, 32'(m ? r_m1_gnt : r_m0_gnt), 32'd1);
    check({name, " other_gnt"}, 32'(m ? r_m0_gnt : r_m1_gnt), 32'd0);
    @(negedge clk);
    m0_req = 1'b0; m1_req = 1'b0;
    s_rdata = srd;
    #1;
    check({name, " s_en"}, 32'(r_s_en), 32'(!exp_err));
    check({name, " s_rw"}, 32'(r_s_rw), 32'(exp_rw));
    check({name, " s_addr"}, r_s_addr, exp_saddr);
    check({name, " s_wdata"}, r_s_wdata, exp_swdata);
    check({name, " early_rvalid"}, 32'(r_m0_rvalid | r_m1_rvalid), 32'd0);
    @(negedge clk);
    #1;
    check({name, " rvalid"}, 32'(m ? r_m1_rvalid : r_m0_rvalid), 32'd1);
    check({name, " other_rvalid"}, 32'(m ? r_m0_rvalid : r_m1_rvalid), 32'd0);
    check({name, " err"}, 32'(m ? r_m1_err : r_m0_err), 32'(exp_err));
    check({name, " rdata"}, m ? r_m1_rdata : r_m0_rdata, exp_rdata);
    check({name, " s_en_resp"}, 32'(r_s_en), 32'd0);
    @(negedge clk);
    s_rdata = '0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    #1;
    check("reset s_en", 32'(r_s_en), 32'd0);
    check("reset s_addr", r_s_addr, 32'd0);
    check("reset rvalid", 32'(r_m0_rvalid | r_m1_rvalid), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run_txn("m0_word_ld", 1'b0, 1'b0, 4'b1111, 1'b1, 32'h100, 32'h0, 32'hDEADBEEF,
            4'b0000, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0);
    run_txn("m1_sbyte_ld", 1'b1, 1'b0, 4'b0001, 1'b0, 32'h103, 32'h0, 32'h80FFFFFF,
            4'b0000, 32'h100, 32'h0, 32'hFFFFFF80, 1'b0);
    run_txn("m1_ubyte_ld", 1'b1, 1'b0, 4'b0001, 1'b1, 32'h103, 32'h0, 32'h80FFFFFF,
            4'b0000, 32'h100, 32'h0, 32'h00000080, 1'b0);
    run_txn("m0_shalf_ld", 1'b0, 1'b0, 4'b0011, 1'b0, 32'h42, 32'h0, 32'h9234_0000,
            4'b0000, 32'h40, 32'h0, 32'hFFFF9234, 1'b0);
    run_txn("m0_half_st", 1'b0, 1'b1, 4'b0011, 1'b0, 32'h22, 32'h0000ABCD, 32'h12345678,
            4'b1100, 32'h20, 32'hABCD0000, 32'h0, 1'b0);
    run_txn("m1_byte_st", 1'b1, 1'b1, 4'b0001, 1'b0, 32'h201, 32'h0000005A, 32'h0,
            4'b0010, 32'h200, 32'h00005A00, 32'h0, 1'b0);
    run_txn("m0_misalign_w", 1'b0, 1'b0, 4'b1111, 1'b0, 32'h102, 32'h0, 32'hDEADBEEF,
            4'b0000, 32'h0, 32'h0, 32'h0, 1'b1);
    run_txn("m0_bad_mask", 1'b0, 1'b0, 4'b0101, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF,
            4'b0000, 32'h0, 32'h0, 32'h0, 1'b1);
    run_txn("m1_misalign_h", 1'b1, 1'b1, 4'b0011, 1'b0, 32'h101, 32'h1234, 32'h0,
            4'b0000, 32'h0, 32'h0, 32'h0, 1'b1);

    // Reset during ACCESS drops the transaction.
    m1_req = 1'b1; m1_we = 1'b0; m1_byte_mask = 4'b1111; m1_addr = 32'h300;
    @(negedge clk);
    m1_req = 1'b0;
    #1;
    check("rst_mid s_en_before", 32'(r_s_en), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check("rst_mid s_en_async", 32'(r_s_en), 32'd0);
    check("rst_mid s_addr_async", r_s_addr, 32'd0);
    @(negedge clk);
    #1;
    check("rst_mid no_rvalid", 32'(r_m0_rvalid | r_m1_rvalid | f_m0_rvalid | f_m1_rvalid), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Both masters request continuously from reset release.
    m0_req = 1'b1; m0_we = 1'b0; m0_byte_mask = 4'b1111; m0_addr = 32'h10;
    m1_req = 1'b1; m1_we = 1'b0; m1_byte_mask = 4'b1111; m1_addr = 32'h20;
    for (int k = 0; k < 12; k++) begin
      #1;
      check($sformatf("rr m0_gnt c%0d", k), 32'(r_m0_gnt),
            32'((k % 3 == 0) && ((k / 3) % 2 == 0)));
      check($sformatf("rr m1_gnt c%0d", k), 32'(r_m1_gnt),
            32'((k % 3 == 0) && ((k / 3) % 2 == 1)));
      check($sformatf("fp m0_gnt c%0d", k), 32'(f_m0_gnt), 32'(k % 3 == 0));
      check($sformatf("fp m1_gnt c%0d", k), 32'(f_m1_gnt), 32'd0);
      @(negedge clk);
    end
    idle_inputs();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, tests run %0d", n_tests);
    $fatal(1);
  end

endmodule

// File: doc/sb_arbiter.md
# sb_arbiter

Sequential two-master arbiter and access sequencer for the single data-memory port. It sits between the executrol load/store path (master 0) and a second requester such as a debug or DMA port (master 1). It owns arbitration, byte-lane steering and load extension. Each transaction is registered through a three-state FSM, so the slave sees glitch-free address, strobe and data.

## Interface
- `RR_EN`, default 1: 1 selects round-robin between the masters; 0 selects fixed priority, with m0 always winning.
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous and active-low.
- `m0_req`, `m1_req` in 1: request, held until the matching `gnt` is seen.
- `m0_we`, `m1_we` in 1: 1 = store, 0 = load; sampled with `req`.
- `m0_byte_mask`, `m1_byte_mask` in 4: access size; `4'b1111` word, `4'b0011` half, `4'b0001` byte; any other value is an error.
- `m0_un_sign`, `m1_un_sign` in 1: 1 = zero-extend loads, 0 = sign-extend.
- `m0_addr`, `m1_addr` in 32: byte address.
- `m0_wdata`, `m1_wdata` in 32: store data, right-aligned.
- `m0_gnt`, `m1_gnt` out 1: one-cycle pulse; the request is accepted this cycle.
- `m0_rvalid`, `m1_rvalid` out 1: one-cycle completion pulse, for both loads and stores.
- `m0_err`, `m1_err` out 1: valid with `rvalid`; indicates a misaligned access or an illegal mask.
- `m0_rdata`, `m1_rdata` out 32: extended load data, valid with `rvalid`; 0 otherwise.
- `s_en_o` out 1: slave access strobe.
- `s_rw_o` out 4: per-byte write enables; `4'b0000` = read.
- `s_addr_o` out 32: word-aligned address (`addr[1:0]` forced to 0).
- `s_wdata_o` out 32: lane-shifted store data.
- `s_rdata` in 32: read data, valid the cycle after `s_en_o`.

## Operation
- **FSM states:** IDLE, ACCESS, RESP.
- **IDLE:**
  - If any `req` is high, pick a winner.
  - Assert that master's `gnt`, which is combinational from `req` and state.
  - Register `we`, `mask`, `un_sign`, `addr` and `wdata` plus a master-id bit, then go to ACCESS.
  - If no `req` is high, stay in IDLE.
- **Winner selection:**
  - If only one master requests, it wins.
  - If both request with `RR_EN=1`, the master not granted last wins; after reset m0 wins the first tie.
  - If both request with `RR_EN=0`, m0 wins.
- **Legality check:** `err = illegal mask | (half & addr[0]) | (word & |addr[1:0])`.
- **ACCESS:**
  - If `err=0`: `s_en_o=1`; `s_rw_o = we ? (mask << addr[1:0]) : 4'b0000`; `s_wdata_o = wdata << (8*addr[1:0])`.
  - If `err=1`: `s_en_o=0` and `s_rw_o=0`; no slave access occurs.
  - Always go to RESP.
- **RESP:**
  - Shift `s_rdata` right by `8*addr[1:0]`.
  - Byte loads extend bit 7; half loads extend bit 15; word loads pass through.
  - Extension is zero when `un_sign=1` and sign when `un_sign=0`.
  - Pulse `rvalid` and `err` of the owning master. `rdata` is 0 for stores and for errors.
  - Go to IDLE.
- **Requests during ACCESS or RESP:** ignored (no `gnt`). Masters hold `req`.
- **Reset:**
  - All outputs go to 0, the FSM to IDLE, and the last-grant pointer to m1, so m0 wins the first tie.
  - An in-flight transaction is dropped: no `rvalid`, and slave outputs clear immediately because reset is asynchronous.

## Timing
- **Cycle 0:** `gnt` (IDLE, `req` high).
- **Cycle 1:** slave outputs driven (ACCESS).
- **Cycle 2:** `rvalid` (RESP). Earliest next `gnt` is cycle 3.
- Sustained throughput is one transaction per 3 cycles.
- Slave outputs (`s_en_o`, `s_rw_o`, `s_addr_o`, `s_wdata_o`) are registered and nonzero only in ACCESS.
- `rdata`, `rvalid` and `err` are combinational from registered state plus `s_rdata`, valid only in RESP.
- `gnt` is combinational; a master must not change request fields in the cycle `gnt` is high.
- Only one of `m0_gnt`/`m1_gnt` is high per cycle; likewise for `rvalid`.

## Structure
- The shared defines package provides:
  - `ZERO32` and `BYTE_SEL`.
  - Mask encodings `MASK_B`/`MASK_H`/`MASK_W`.
  - FSM state encoding: IDLE=2'd0, ACCESS=2'd1, RESP=2'd2.
- One sub-module, `sb_load_ext`, is combinational. It takes `rdata`, `offset[1:0]`, `mask` and `un_sign` and returns the extended 32-bit word; it is reused by any future load path.
- The arbiter FSM, request register and lane steering stay in `sb_arbiter`.

## Test plan
- **Single m0 word load:** `addr=0x100`, `s_rdata=0xDEADBEEF`. `gnt` at c0, `s_en_o=1`/`s_rw_o=0`/`s_addr_o=0x100` at c1, `m0_rvalid`/`m0_rdata=0xDEADBEEF` at c2.
- **m1 signed byte load:** `addr=0x103`, `s_rdata=0x80FF_FFFF`, `un_sign=0`. `m1_rdata=0xFFFFFF80`. Repeat with `un_sign=1`: `m1_rdata=0x00000080`.
- **m0 half store:** `addr=0x22`, `wdata=0x0000ABCD`. At ACCESS: `s_rw_o=4'b1100`, `s_wdata_o=0xABCD0000`, `s_addr_o=0x20`. `m0_rvalid=1`, `m0_rdata=0`.
- **Both masters requesting continuously, `RR_EN=1`:** grants go m0, m1, m0, m1 at cycles 0, 3, 6, 9. With `RR_EN=0`: m0 at every grant, m1 never.
- **Misaligned word at `0x102`:**
  - No `s_en_o` pulse.
  - `m0_rvalid=1` and `m0_err=1` at c2, `m0_rdata=0`.
  - A mask of `4'b0101` gives the same result.
- **Reset mid-transaction:** `rst` driven low during ACCESS. `s_en_o` drops asynchronously, and no `rvalid` is issued. After release with both requesting, m0 is granted first.
